// File: rtl/lsu_mem_port_pkg.sv
// Shared access-size constants, LSU state encoding and the alignment rule.
package lsu_mem_port_pkg;

    // mem_mask_d has the same value as the existing decoder define.
    localparam logic [7:0] mem_mask_b = 8'h01;
    localparam logic [7:0] mem_mask_h = 8'h03;
    localparam logic [7:0] mem_mask_w = 8'h0F;
    localparam logic [7:0] mem_mask_d = 8'hFF;

    typedef enum logic [1:0] {
        LSU_IDLE = 2'd0,
        LSU_REQ  = 2'd1,
        LSU_WAIT = 2'd2,
        LSU_DONE = 2'd3
    } lsu_state_e;

    // Legal iff the mask is a known size and the offset is a multiple of it.
    function automatic logic access_legal(input logic [7:0] mask, input logic [2:0] off);
        case (mask)
            mem_mask_b: return 1'b1;
            mem_mask_h: return ~off[0];
            mem_mask_w: return off[1:0] == 2'b00;
            mem_mask_d: return off == 3'b000;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Aligns a raw bus doubleword to the access offset and sign/zero-extends it.
module lsu_load_ext
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic [XLEN-1:0] raw,
    input  logic [2:0]      off,
    input  logic [7:0]      mask,
    input  logic            load_unsigned,
    output logic [XLEN-1:0] data
);

    logic [XLEN-1:0] sh;

    always_comb begin
        sh   = raw >> {off, 3'b000};
        data = sh;
        case (mask)
            mem_mask_b: data = {{(XLEN-8){sh[7] & ~load_unsigned}}, sh[7:0]};
            mem_mask_h: data = {{(XLEN-16){sh[15] & ~load_unsigned}}, sh[15:0]};
            mem_mask_w: data = {{(XLEN-32){sh[31] & ~load_unsigned}}, sh[31:0]};
            default:    data = sh;
        endcase
    end

endmodule

// File: rtl/lsu_mem_port.sv
// Load/store port: turns one core request into a byte-strobed aligned bus
// transaction and stalls the core until it completes.
//
// state | meaning
// IDLE  | waiting for start; illegal requests pulse err here
// REQ   | req_valid high, fields held until req_ready
// WAIT  | handshake done, waiting for resp_valid
// DONE  | one-cycle done pulse, stall released
module lsu_mem_port
    import lsu_mem_port_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int AW     = 64,
    parameter int STRB_W = XLEN / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mem_wen,
    input  logic [STRB_W-1:0] mem_mask,
    input  logic              load_unsigned,
    input  logic [AW-1:0]     addr,
    input  logic [XLEN-1:0]   wdata,
    output logic              stall,
    output logic              done,
    output logic              err,
    output logic [XLEN-1:0]   rdata,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_wen,
    output logic [AW-1:0]     req_addr,
    output logic [STRB_W-1:0] req_wstrb,
    output logic [XLEN-1:0]   req_wdata,
    input  logic              resp_valid,
    input  logic [XLEN-1:0]   resp_rdata
);

    lsu_state_e        state, state_nxt;
    logic              legal;
    logic              accept;
    logic [2:0]        off_q;
    logic [STRB_W-1:0] mask_q;
    logic              uns_q;
    logic [XLEN-1:0]   ext_data;

    assign legal  = access_legal(mem_mask, addr[2:0]);
    assign accept = (state == LSU_IDLE) && start && legal;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= LSU_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            LSU_IDLE: if (start && legal) state_nxt = LSU_REQ;
            LSU_REQ:  if (req_ready)      state_nxt = LSU_WAIT;
            LSU_WAIT: if (resp_valid)     state_nxt = LSU_DONE;
            LSU_DONE:                     state_nxt = LSU_IDLE;
            default:                      state_nxt = LSU_IDLE;
        endcase
    end

    // Decoded from state alone so reset drops req_valid/stall without a clock.
    always_comb begin
        stall     = (state == LSU_REQ) || (state == LSU_WAIT);
        done      = (state == LSU_DONE);
        req_valid = (state == LSU_REQ);
    end

    lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
        .raw           (resp_rdata),
        .off           (off_q),
        .mask          (mask_q),
        .load_unsigned (uns_q),
        .data          (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err       <= 1'b0;
            off_q     <= '0;
            mask_q    <= '0;
            uns_q     <= 1'b0;
            req_wen   <= 1'b0;
            req_addr  <= '0;
            req_wstrb <= '0;
            req_wdata <= '0;
            rdata     <= '0;
        end else begin
            err <= (state == LSU_IDLE) && start && !legal;
            if (accept) begin
                off_q     <= addr[2:0];
                mask_q    <= mem_mask;
                uns_q     <= load_unsigned;
                req_wen   <= mem_wen;
                req_addr  <= {addr[AW-1:3], 3'b000};
                req_wstrb <= mem_wen ? (mem_mask << addr[2:0]) : '0;
                req_wdata <= wdata << {addr[2:0], 3'b000};
            end
            if ((state == LSU_WAIT) && resp_valid && !req_wen)
                rdata <= ext_data;
        end
    end

endmodule

// File: tb/tb_lsu_mem_port.sv
// Randomized and directed bench for lsu_mem_port against a byte-level model.
module tb_lsu_mem_port;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, mem_wen, load_unsigned;
    logic [7:0]  mem_mask;
    logic [63:0] addr, wdata;
    logic        stall, done, err;
    logic [63:0] rdata;
    logic        req_valid, req_ready, req_wen;
    logic [63:0] req_addr;
    logic [7:0]  req_wstrb;
    logic [63:0] req_wdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;

    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [63:0] exp_rdata;

    lsu_mem_port dut (
        .clk(clk), .rst(rst), .start(start), .mem_wen(mem_wen), .mem_mask(mem_mask),
        .load_unsigned(load_unsigned), .addr(addr), .wdata(wdata), .stall(stall),
        .done(done), .err(err), .rdata(rdata), .req_valid(req_valid),
        .req_ready(req_ready), .req_wen(req_wen), .req_addr(req_addr),
        .req_wstrb(req_wstrb), .req_wdata(req_wdata), .resp_valid(resp_valid),
        .resp_rdata(resp_rdata)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_load(input logic [63:0] resp, input int off,
                                             input int size, input logic uns);
        logic [127:0] v, keep;
        keep = (128'd1 << (8 * size)) - 1;
        v    = ({64'd0, resp} >> (8 * off)) & keep;
        if (!uns && size < 8 && v[8 * size - 1]) v = v | ~keep;
        return v[63:0];
    endfunction

    task automatic run_txn(input logic wen, input logic [7:0] mask, input logic uns,
                           input logic [63:0] a, input logic [63:0] wd, input int rdly,
                           input int pdly, input logic [63:0] resp, input logic early);
        int           size, off, t0;
        logic         legal;
        logic [7:0]   e_strb;
        logic [127:0] wide;
        logic [63:0]  e_addr, e_wdata;
        size  = $countones(mask);
        off   = int'(a[2:0]);
        legal = (mask == 8'h01 || mask == 8'h03 || mask == 8'h0F || mask == 8'hFF);
        if (legal) legal = (off % size) == 0;
        e_strb = '0;
        for (int i = 0; i < 8; i++) e_strb[i] = wen && (i >= off) && (i < off + size);
        wide    = {64'd0, wd} << (8 * off);
        e_wdata = wide[63:0];
        e_addr  = a - 64'(off);

        @(negedge clk);
        start = 1'b1; mem_wen = wen; mem_mask = mask; load_unsigned = uns;
        addr = a; wdata = wd; t0 = cyc;
        @(negedge clk);
        start = 1'b0; mem_wen = $urandom; mem_mask = 8'($urandom); addr = {$urandom, $urandom};
        if (!legal) begin
            chk("err_pulse", 64'(err), 64'd1);
            chk("err_stall", 64'(stall), 64'd0);
            chk("err_noreq", 64'(req_valid), 64'd0);
            @(negedge clk);
            chk("err_once", 64'(err), 64'd0);
            chk("err_noreq2", 64'(req_valid), 64'd0);
            return;
        end
        chk("err_none", 64'(err), 64'd0);
        chk("req_valid", 64'(req_valid), 64'd1);
        chk("req_stall", 64'(stall), 64'd1);
        chk("req_wen", 64'(req_wen), 64'(wen));
        chk("req_addr", req_addr, e_addr);
        chk("req_wstrb", 64'(req_wstrb), 64'(e_strb));
        chk("req_wdata", req_wdata, e_wdata);
        for (int i = 0; i < rdly; i++) begin
            @(negedge clk);
            chk("hold_valid", 64'({req_valid, stall, done}), 64'b110);
            chk("hold_fields", req_addr ^ req_wdata ^ 64'({req_wen, req_wstrb}),
                e_addr ^ e_wdata ^ 64'({wen, e_strb}));
        end
        req_ready = 1'b1; resp_valid = early; resp_rdata = ~resp;
        @(negedge clk);
        req_ready = 1'b0; resp_valid = 1'b0;
        chk("wait_valid", 64'(req_valid), 64'd0);
        chk("wait_state", 64'({stall, done}), 64'b10);
        for (int i = 0; i < pdly; i++) begin
            @(negedge clk);
            chk("wait_hold", 64'({stall, done}), 64'b10);
        end
        resp_valid = 1'b1; resp_rdata = resp;
        @(negedge clk);
        resp_valid = 1'b0;
        if (!wen) exp_rdata = ref_load(resp, off, size, uns);
        chk("done_pulse", 64'({stall, done}), 64'b01);
        chk("latency", 64'(cyc - t0), 64'(3 + rdly + pdly));
        chk("rdata", rdata, exp_rdata);
        @(negedge clk);
        chk("done_once", 64'({stall, done}), 64'b00);
        chk("rdata_hold", rdata, exp_rdata);
    endtask

    initial begin
        logic [7:0]  m;
        logic [63:0] a;
        int          pick;
        rst = 1'b1; start = 1'b0; mem_wen = 1'b0; mem_mask = 8'h00; load_unsigned = 1'b0;
        addr = '0; wdata = '0; req_ready = 1'b0; resp_valid = 1'b0; resp_rdata = '0;
        exp_rdata = '0;
        #1;
        chk("rst_ctrl", 64'({stall, done, err, req_valid, req_wen}), 64'd0);
        chk("rst_fields", req_addr | req_wdata | 64'(req_wstrb) | rdata, 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;

        // store byte
        run_txn(1'b1, 8'h01, 1'b0, 64'h8000_0005, 64'hAB, 0, 0, 64'h0, 1'b0);
        chk("tp_sb_rdata", rdata, 64'h0);
        // signed / unsigned byte load
        run_txn(1'b0, 8'h01, 1'b0, 64'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_8000_0000, 1'b0);
        chk("tp_lb", rdata, 64'hFFFF_FFFF_FFFF_FF80);
        run_txn(1'b0, 8'h01, 1'b1, 64'h8000_0003, 64'h0, 0, 0, 64'h0000_0000_8000_0000, 1'b0);
        chk("tp_lbu", rdata, 64'h80);
        // backpressure, plus a response coinciding with the handshake
        run_txn(1'b0, 8'h03, 1'b0, 64'h8000_0106, 64'h0, 5, 2, 64'h8001_2345_6789_ABCD, 1'b1);
        chk("tp_lh", rdata, 64'hFFFF_FFFF_FFFF_8001);
        // misaligned and illegal mask
        run_txn(1'b0, 8'h0F, 1'b0, 64'h8000_0006, 64'h0, 0, 0, 64'h0, 1'b0);
        run_txn(1'b0, 8'h05, 1'b0, 64'h8000_0000, 64'h0, 0, 0, 64'h0, 1'b0);
        chk("tp_err_rdata", rdata, 64'hFFFF_FFFF_FFFF_8001);
        // doubleword store and load
        run_txn(1'b1, 8'hFF, 1'b0, 64'h8000_0008, 64'h1122_3344_5566_7788, 0, 0, 64'h0, 1'b0);
        chk("tp_sd_strb", 64'(req_wstrb), 64'hFF);
        run_txn(1'b0, 8'hFF, 1'b0, 64'h8000_0008, 64'h0, 0, 0, 64'h1122_3344_5566_7788, 1'b0);
        chk("tp_ld", rdata, 64'h1122_3344_5566_7788);

        // async reset while waiting for the response
        @(negedge clk);
        start = 1'b1; mem_wen = 1'b0; mem_mask = 8'h0F; addr = 64'h8000_0004;
        @(negedge clk);
        start = 1'b0; req_ready = 1'b1;
        @(negedge clk);
        req_ready = 1'b0;
        chk("pre_rst_stall", 64'(stall), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_stall", 64'({stall, req_valid, done}), 64'd0);
        chk("rst_mid_rdata", rdata, 64'd0);
        exp_rdata = '0;
        @(negedge clk);
        rst = 1'b0; resp_valid = 1'b1; resp_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        resp_valid = 1'b0;
        chk("rst_resp_ign", 64'({stall, done, req_valid}), 64'd0);
        chk("rst_resp_rdata", rdata, 64'd0);
        run_txn(1'b0, 8'h0F, 1'b1, 64'h8000_0004, 64'h0, 1, 1, 64'hF00D_CAFE_0000_0000, 1'b0);
        chk("post_rst_lwu", rdata, 64'h0000_0000_F00D_CAFE);

        for (int n = 0; n < 300; n++) begin
            pick = $urandom_range(0, 9);
            case (pick)
                0, 1:    m = 8'h01;
                2, 3:    m = 8'h03;
                4, 5:    m = 8'h0F;
                6, 7:    m = 8'hFF;
                default: m = 8'($urandom);
            endcase
            a = {$urandom, $urandom};
            if ($urandom_range(0, 3) != 0) begin
                case (m)
                    8'h03:   a[0] = 1'b0;
                    8'h0F:   a[1:0] = 2'b00;
                    8'hFF:   a[2:0] = 3'b000;
                    default: ;
                endcase
            end
            run_txn(1'($urandom), m, 1'($urandom), a, {$urandom, $urandom},
                    $urandom_range(0, 3), $urandom_range(0, 3), {$urandom, $urandom},
                    1'($urandom));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/lsu_mem_port.md
Name: lsu_mem_port

Overview:
- Memory-side responder for the `mem_wen`/`mem_mask` control outputs of the LemonPC decoder.
- Takes one load or store request per instruction from the core datapath and turns it into an 8-byte-aligned, byte-strobed transaction on a valid/ready memory bus.
- Returns load data that is shifted and sign/zero-extended.
- Holds `stall` high so the core freezes the PC until the access completes.

Parameters:
- XLEN, 64, data width of the core and the bus.
- AW, 64, address width.
- STRB_W, XLEN/8, byte-strobe width (8).

Ports:
- clk  in  1  clock; everything is updated on the rising edge.
- rst  in  1  reset; asynchronous, active-high.
- start  in  1  one-cycle request from the core; sampled only in IDLE.
- mem_wen  in  1  1 = store, 0 = load.
- mem_mask  in  STRB_W  access size: 8'h01 = byte, 8'h03 = half, 8'h0F = word, 8'hFF = double.
- load_unsigned  in  1  zero-extend the load result instead of sign-extending it.
- addr  in  AW  byte address computed by the ALU.
- wdata  in  XLEN  store data, LSB-justified (taken from rs2).
- stall  out  1  high while a transaction is in flight.
- done  out  1  one-cycle completion pulse.
- err  out  1  one-cycle pulse for a misaligned or illegal mask; no bus traffic is issued.
- rdata  out  XLEN  extended load result; valid with `done` and held until the next `done`.
- req_valid  out  1  bus request valid.
- req_ready  in  1  bus accepts the request.
- req_wen  out  1  bus write enable.
- req_addr  out  AW  `{addr[AW-1:3], 3'b0}`.
- req_wstrb  out  STRB_W  `mem_mask << addr[2:0]`; zero for loads.
- req_wdata  out  XLEN  `wdata << (8*addr[2:0])`.
- resp_valid  in  1  bus response or write acknowledge.
- resp_rdata  in  XLEN  raw aligned doubleword.

Behaviour:
- Reset (asynchronous): state = IDLE. `stall`, `done`, `err`, `req_valid`, `req_wen` = 0. `req_addr`, `req_wstrb`, `req_wdata`, `rdata` = 0. All latched request fields = 0.
- States are IDLE, REQ, WAIT, DONE.
- IDLE + `start`:
  - Legality check: `mem_mask` must be one of {01, 03, 0F, FF} and `addr[2:0]` must be a multiple of the access size.
  - Illegal: pulse `err` for 1 cycle, stay in IDLE, `stall` stays 0.
  - Legal: latch `addr[2:0]`, `mem_mask`, `load_unsigned` and the bus fields; go to REQ. `stall` = 1 from the next cycle.
- REQ:
  - `req_valid` = 1 and all req_* fields are stable until the handshake.
  - On `req_valid && req_ready`: go to WAIT. `req_valid` drops the following cycle.
- WAIT:
  - On `resp_valid`: go to DONE.
  - For loads, register `rdata = ext((resp_rdata >> 8*off) & size_mask)`.
  - Extension: sign-extend from the top byte of the access unless `load_unsigned`. For FF there is no extension.
  - Stores ignore `resp_rdata` and leave `rdata` unchanged.
- DONE:
  - `done` = 1 and `stall` = 0 for exactly 1 cycle, then IDLE.
  - `start` is ignored in DONE; it is accepted again in the next cycle.
- Minimum latency: `start` → `done` = 3 cycles, given ready and response in the same cycle as each request.
- `resp_valid` outside WAIT is ignored, including a response arriving in the same cycle as the handshake.
- `start` while not IDLE is ignored (the core is stalled and must not assert it).
- Reset mid-transaction drops the request immediately: `req_valid` = 0 asynchronously. No `done` is produced.

Decomposition:
- Shared package/defines alongside the existing `defines.v`:
  - `mem_mask_b`/`h`/`w`/`d` constants: 8'h01 / 03 / 0F / FF; `mem_mask_d` must match the existing define.
  - LSU state encodings.
- Sub-module `lsu_load_ext` (combinational): shift, mask and sign/zero-extension of `resp_rdata`.

Test Plan:
- Store byte: `addr` = 0x8000_0005, `mask` = 01, `wdata` = 0xAB → `req_addr` = 0x8000_0000, `wstrb` = 8'h20, `wdata` = 0x0000_AB00_0000_0000; `done` 3 cycles after `start`.
- Load byte signed: `addr` = 0x...3, `resp_rdata` = 0x0000_0000_8000_0000 → `rdata` = 0xFFFF_FFFF_FFFF_FF80. With `load_unsigned` → `rdata` = 0x80.
- Backpressure: hold `req_ready` = 0 for 5 cycles → `req_valid` and all fields stable, `stall` = 1 throughout; `done` arrives exactly 1 cycle after `resp_valid`.
- Misaligned: word load at `addr` = 0x...6, or `mask` = 8'h05 → `err` pulse, no `req_valid`, `stall` stays 0.
- Async reset asserted while in WAIT → `req_valid`, `stall` = 0 immediately; a later `resp_valid` is ignored; a next legal `start` completes normally.
- Full doubleword store then load (`sd`, `mask` = FF at `addr` = 0x...8) → `wstrb` = FF; the load returns 0x1122_3344_5566_7788 unmodified.
